sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
Sequences the shared SDRAM command/address/data pins between four masters: initialisation, auto-refresh, burst write and burst read. It sits between those four masters and the SDRAM pad interface. After init completes it grants the bus to one master at a time by fixed priority, holds the grant until that master's end pulse, and muxes the granted master's cmd/ba/addr and write-data onto the pins.

Parameters:
DATA_W, 16, SDRAM DQ width
ADDR_W, 13, SDRAM A-bus width (A12..A0)
BA_W, 2, bank address width

Ports:
sys_clk  in  1  system clock, 100 MHz
sys_rst  in  1  synchronous reset, active-high
init_end  in  1  level; init sequence finished
init_cmd  in  4  init {cs_n,ras_n,cas_n,we_n}
init_ba  in  BA_W  init bank
init_addr  in  ADDR_W  init address
aref_req  in  1  level; refresh due
aref_end  in  1  1-cycle pulse; refresh done
aref_cmd/aref_ba/aref_addr  in  4/BA_W/ADDR_W  refresh command bus
wr_req  in  1  level; write FIFO has a burst ready
wr_end  in  1  1-cycle pulse; write burst done
wr_cmd/wr_ba/wr_addr  in  4/BA_W/ADDR_W  write command bus
wr_sdram_en  in  1  write master drives DQ
wr_sdram_data  in  DATA_W  write data
rd_req  in  1  level; read burst wanted
rd_end  in  1  1-cycle pulse; read burst done
rd_cmd/rd_ba/rd_addr  in  4/BA_W/ADDR_W  read command bus
aref_en  out  1  start/hold refresh master
wr_en  out  1  start/hold write master
rd_en  out  1  start/hold read master
sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to pins
sdram_ba  out  BA_W  bank to pins
sdram_addr  out  ADDR_W  address to pins
sdram_dq_oe  out  1  DQ tristate output enable
sdram_dq_out  out  DATA_W  DQ output data

Behaviour:
- States: IDLE, ARBIT, AREF, WRITE, READ. Reset: state=IDLE; aref_en/wr_en/rd_en=0.
- IDLE: stay until init_end=1, then ARBIT next edge. init_end ignored in all other states.
- ARBIT: priority aref_req > wr_req > rd_req. The winner moves state to AREF/WRITE/READ and sets its *_en to 1 on the same edge. No request: stay in ARBIT.
- AREF/WRITE/READ: hold until the matching *_end=1. On that edge: state goes to ARBIT and *_en clears to 0. The master therefore sees en=0 when it returns to its idle state and does not retrigger.
- No preemption. A request arriving mid-grant waits. Requests are level-sampled only in ARBIT.
- At least one ARBIT cycle between consecutive grants, even if a request is pending at the end pulse.
- End pulses from non-granted masters are ignored: no state or en change.
- Output mux is combinational from state (zero latency):
  - IDLE: init_cmd/ba/addr.
  - AREF/WRITE/READ: that master's cmd/ba/addr.
  - ARBIT: NOP 4'b0111, ba all-ones, addr all-ones.
- sdram_dq_oe = wr_sdram_en when state=WRITE, else 0.
- sdram_dq_out = wr_sdram_data when sdram_dq_oe=1, else 0.
- Reset mid-grant: next edge state=IDLE, all en=0, pins follow init bus.
- Encoding: one-hot or binary is free. Unreachable states recover to IDLE.

Optional Feature:
SDRAM_ARBIT_RR_EN
- Defined: wr_req and rd_req are round-robin between themselves. A last_wr flag is set on a write grant and cleared on a read grant; reset value is 0. If both are pending in ARBIT, the one not last granted wins. aref_req still beats both.
- Undefined: fixed priority wr > rd; no last_wr flag.

Test Plan:
- Reset, init_cmd=4'b0010, init_end=0 for 10 cycles -> sdram_cmd=4'b0010 throughout, all en=0. Then init_end=1 -> ARBIT next cycle, sdram_cmd=4'b0111, addr=13'h1fff.
- ARBIT with aref_req=wr_req=rd_req=1 -> aref_en=1 next cycle. Pulse aref_end -> aref_en=0, one ARBIT cycle, then wr_en=1.
- Write grant, wr_sdram_en=1 with data 16'hA5A5..A5AC over 8 cycles -> sdram_dq_oe=1 and dq_out matches each cycle. Raise aref_req mid-burst -> no preemption; aref_en=1 only after wr_end plus one ARBIT cycle.
- rd_end/aref_end pulsed during a write grant -> wr_en stays 1, state unchanged.
- sys_rst=1 for 1 cycle during a read grant -> rd_en=0 next cycle, pins follow init bus, re-arbitration waits for init_end.
- SDRAM_ARBIT_RR_EN defined, wr_req=rd_req=1 held, four grants -> order W,R,W,R. Undefined -> W,W,W,W.

Source files
------------

// File: rtl/sdram_arbit.sv
// sdram_arbit: shares the SDRAM command/address/data pins between the
// init, auto-refresh, burst-write and burst-read masters.
//
// Once init_end is seen, the bus is granted to one master at a time by
// priority aref > wr > rd. A grant is held until that master's end pulse.
// Every grant is followed by at least one ARBIT cycle.
//
// Optional feature macro: SDRAM_ARBIT_RR_EN
//   When defined, write and read take turns (round-robin) when both are
//   pending. Refresh still wins over both.
//
// Ports:
//   sys_clk, sys_rst        clock; synchronous active-high reset
//   init_*                  init master bus (cmd/ba/addr), init_end level
//   aref_*/wr_*/rd_*        refresh/write/read request, end pulse, cmd bus
//   wr_sdram_en/_data       write master DQ drive enable and data
//   aref_en/wr_en/rd_en     registered grant to each master
//   sdram_cmd/ba/addr       pin-side command bus (combinational from state)
//   sdram_dq_oe/_dq_out     pin-side DQ output enable and data
module sdram_arbit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned BA_W   = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_dq_oe,
    output logic [DATA_W-1:0] sdram_dq_out
);

    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   pick_wr;

`ifdef SDRAM_ARBIT_RR_EN
    // Set on a write grant, cleared on a read grant.
    logic last_wr;

    // With both pending, the write only wins if the read was granted last.
    assign pick_wr = wr_req && !(rd_req && last_wr);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            last_wr <= 1'b0;
        end else if (state == S_ARBIT && !aref_req) begin
            if (pick_wr) begin
                last_wr <= 1'b1;
            end else if (rd_req) begin
                last_wr <= 1'b0;
            end
        end
    end
`else
    assign pick_wr = wr_req;
`endif

    // Next-state: grant from ARBIT, release on the granted master's end pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (init_end) state_nxt = S_ARBIT;
            S_ARBIT: begin
                if (aref_req)     state_nxt = S_AREF;
                else if (pick_wr) state_nxt = S_WRITE;
                else if (rd_req)  state_nxt = S_READ;
            end
            S_AREF:  if (aref_end) state_nxt = S_ARBIT;
            S_WRITE: if (wr_end)   state_nxt = S_ARBIT;
            S_READ:  if (rd_end)   state_nxt = S_ARBIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; grants follow the next state so they rise and fall
    // on the same edge as the state change.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= S_IDLE;
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            state   <= state_nxt;
            aref_en <= (state_nxt == S_AREF);
            wr_en   <= (state_nxt == S_WRITE);
            rd_en   <= (state_nxt == S_READ);
        end
    end

    // Pin mux, zero latency from the current state.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_ba   = '1;
        sdram_addr = '1;
        case (state)
            S_IDLE: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            S_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            S_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    // Only the write master may drive DQ, and only while it holds the bus.
    assign sdram_dq_oe  = (state == S_WRITE) && wr_sdram_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed and randomized checks of sdram_arbit against a
// behavioural model of who owns the SDRAM bus.
module tb_sdram_arbit;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned BA_W   = 2;

    // Bus owner codes used by the model.
    localparam int OWN_INIT = 0;
    localparam int OWN_NONE = 1;
    localparam int OWN_AREF = 2;
    localparam int OWN_WR   = 3;
    localparam int OWN_RD   = 4;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              aref_req, aref_end;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              wr_req, wr_end;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_sdram_data;
    logic              rd_req, rd_end;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic              aref_en, wr_en, rd_en;
    logic [3:0]        sdram_cmd;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic              sdram_dq_oe;
    logic [DATA_W-1:0] sdram_dq_out;

    sdram_arbit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BA_W(BA_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
        .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_oe(sdram_dq_oe), .sdram_dq_out(sdram_dq_out)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Model: who owns the bus, plus the round-robin memory when enabled.
    int owner = OWN_INIT;
`ifdef SDRAM_ARBIT_RR_EN
    bit wr_was_last = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the ownership rules to the inputs present at a rising edge.
    task automatic model_edge();
        int winner;
        if (sys_rst) begin
            owner = OWN_INIT;
`ifdef SDRAM_ARBIT_RR_EN
            wr_was_last = 1'b0;
`endif
        end else if (owner == OWN_INIT) begin
            if (init_end) owner = OWN_NONE;
        end else if (owner == OWN_NONE) begin
            winner = OWN_NONE;
            if (aref_req) winner = OWN_AREF;
            else if (wr_req && rd_req) begin
`ifdef SDRAM_ARBIT_RR_EN
                winner = wr_was_last ? OWN_RD : OWN_WR;
`else
                winner = OWN_WR;
`endif
            end
            else if (wr_req) winner = OWN_WR;
            else if (rd_req) winner = OWN_RD;
`ifdef SDRAM_ARBIT_RR_EN
            if (winner == OWN_WR) wr_was_last = 1'b1;
            if (winner == OWN_RD) wr_was_last = 1'b0;
`endif
            owner = winner;
        end else if ((owner == OWN_AREF && aref_end) || (owner == OWN_WR && wr_end) ||
                     (owner == OWN_RD && rd_end)) begin
            owner = OWN_NONE;
        end
    endtask

    task automatic check_outputs();
        logic [3:0]        e_cmd;
        logic [BA_W-1:0]   e_ba;
        logic [ADDR_W-1:0] e_addr;
        logic              e_oe;
        case (owner)
            OWN_INIT: begin e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr; end
            OWN_AREF: begin e_cmd = aref_cmd; e_ba = aref_ba; e_addr = aref_addr; end
            OWN_WR:   begin e_cmd = wr_cmd;   e_ba = wr_ba;   e_addr = wr_addr;   end
            OWN_RD:   begin e_cmd = rd_cmd;   e_ba = rd_ba;   e_addr = rd_addr;   end
            default:  begin e_cmd = 4'b0111;  e_ba = '1;      e_addr = '1;        end
        endcase
        e_oe = (owner == OWN_WR) && wr_sdram_en;
        check("aref_en", 32'(aref_en), 32'(owner == OWN_AREF));
        check("wr_en",   32'(wr_en),   32'(owner == OWN_WR));
        check("rd_en",   32'(rd_en),   32'(owner == OWN_RD));
        check("cmd",     32'(sdram_cmd),  32'(e_cmd));
        check("ba",      32'(sdram_ba),   32'(e_ba));
        check("addr",    32'(sdram_addr), 32'(e_addr));
        check("dq_oe",   32'(sdram_dq_oe), 32'(e_oe));
        check("dq_out",  32'(sdram_dq_out), e_oe ? 32'(wr_sdram_data) : 32'd0);
    endtask

    // One cycle: model follows the edge, outputs checked on the falling edge;
    // the caller then changes inputs while the clock is low.
    task automatic tick();
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        check_outputs();
    endtask

    initial begin
        int n;
        int exp_order [4];
        sys_rst = 1'b1; init_end = 1'b0;
        init_cmd = 4'b0010; init_ba = 2'd1; init_addr = 13'h0400;
        aref_req = 1'b0; aref_end = 1'b0; aref_cmd = 4'b0001; aref_ba = 2'd2; aref_addr = 13'h0011;
        wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'd3; wr_addr = 13'h0123;
        wr_sdram_en = 1'b0; wr_sdram_data = '0;
        rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'd0; rd_addr = 13'h0456;

        // Reset, then init_end held low for 10 cycles.
        tick(); tick();
        sys_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("init_cmd_hold", 32'(sdram_cmd), 32'h2);
        end
        init_end = 1'b1;
        tick();
        init_end = 1'b0;
        check("arbit_nop", 32'(sdram_cmd), 32'h7);
        check("arbit_addr", 32'(sdram_addr), 32'h1fff);

        // All three requesting: refresh first, then one ARBIT cycle, then write.
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        check("aref_first", 32'(aref_en), 32'd1);
        tick();
        aref_req = 1'b0; aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        check("aref_release", 32'(aref_en), 32'd0);
        check("gap_nop", 32'(sdram_cmd), 32'h7);
        tick();
        check("wr_after_gap", 32'(wr_en), 32'd1);

        // Write burst with refresh raised mid-burst and stray end pulses.
        rd_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_sdram_en = 1'b1;
            wr_sdram_data = 16'hA5A5 + 16'(i);
            if (i == 3) aref_req = 1'b1;
            rd_end = (i == 5);
            aref_end = (i == 6);
            tick();
            check("burst_oe", 32'(sdram_dq_oe), 32'd1);
            check("burst_dq", 32'(sdram_dq_out), 32'hA5A5 + 32'(i));
            check("burst_hold", 32'(wr_en), 32'd1);
        end
        rd_end = 1'b0; aref_end = 1'b0;
        wr_sdram_en = 1'b0; wr_req = 1'b0; wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        check("no_preempt_wr", 32'(wr_en), 32'd0);
        check("no_preempt_aref", 32'(aref_en), 32'd0);
        tick();
        check("aref_after_wr", 32'(aref_en), 32'd1);
        aref_req = 1'b0; aref_end = 1'b1;
        tick();
        aref_end = 1'b0;

        // Read grant interrupted by a one-cycle reset.
        rd_req = 1'b1;
        tick();
        check("rd_grant", 32'(rd_en), 32'd1);
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_init_bus", 32'(sdram_cmd), 32'(init_cmd));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_init", 32'(rd_en), 32'd0);
        end
        init_end = 1'b1;
        tick();
        init_end = 1'b0;

        // Write and read both held: four grants in order.
`ifdef SDRAM_ARBIT_RR_EN
        exp_order = '{OWN_WR, OWN_RD, OWN_WR, OWN_RD};
`else
        exp_order = '{OWN_WR, OWN_WR, OWN_WR, OWN_WR};
`endif
        wr_req = 1'b1; rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(wr_en || rd_en) && n < 10) begin
                tick();
                n++;
            end
            check("grant_seen", 32'(wr_en || rd_en), 32'd1);
            check("grant_order", wr_en ? 32'(OWN_WR) : (rd_en ? 32'(OWN_RD) : 32'd0),
                  32'(exp_order[k]));
            tick();
            wr_end = wr_en; rd_end = rd_en;
            tick();
            wr_end = 1'b0; rd_end = 1'b0;
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            sys_rst  = ($urandom_range(0, 199) == 0);
            init_end = ($urandom_range(0, 3) == 0);
            aref_req = ($urandom_range(0, 7) == 0);
            wr_req   = $urandom_range(0, 1) == 1;
            rd_req   = $urandom_range(0, 1) == 1;
            aref_end = (owner == OWN_AREF) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            wr_end   = (owner == OWN_WR)   ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            rd_end   = (owner == OWN_RD)   ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            init_cmd = 4'($urandom); init_ba = BA_W'($urandom); init_addr = ADDR_W'($urandom);
            aref_cmd = 4'($urandom); aref_ba = BA_W'($urandom); aref_addr = ADDR_W'($urandom);
            wr_cmd   = 4'($urandom); wr_ba   = BA_W'($urandom); wr_addr   = ADDR_W'($urandom);
            rd_cmd   = 4'($urandom); rd_ba   = BA_W'($urandom); rd_addr   = ADDR_W'($urandom);
            wr_sdram_en   = $urandom_range(0, 1) == 1;
            wr_sdram_data = DATA_W'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
